// File: rtl/stream_packer_if.sv
//------------------------------------------------------------------------------
// stream_packer_if : FWFT read side plus write side of a width up-converter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface stream_packer_if #(
  parameter int IN_WIDTH = 33,
  parameter int RATIO    = 4
);
  localparam int PW        = IN_WIDTH - 1;
  localparam int CW        = $clog2(RATIO + 1);
  localparam int OUT_WIDTH = 1 + CW + RATIO * PW;

  logic                 in_empty_n;
  logic                 in_read;
  logic [IN_WIDTH-1:0]  in_dout;
  logic                 out_full_n;
  logic                 out_write;
  logic [OUT_WIDTH-1:0] out_din;

  // master is the packer; slave is whatever surrounds it (relay stations, bench)
  modport master (
    input  in_empty_n,
    input  in_dout,
    input  out_full_n,
    output in_read,
    output out_write,
    output out_din
  );

  modport slave (
    output in_empty_n,
    output in_dout,
    output out_full_n,
    input  in_read,
    input  out_write,
    input  out_din
  );
endinterface

`default_nettype wire

// File: rtl/stream_packer.sv
//------------------------------------------------------------------------------
// stream_packer : packs RATIO narrow tokens into one wide token; EOT flushes
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module stream_packer #(
  parameter int IN_WIDTH  = 33,
  parameter int RATIO     = 4,
  parameter int CW        = $clog2(RATIO + 1),
  parameter int OUT_WIDTH = 1 + CW + RATIO * (IN_WIDTH - 1)
) (
  input  logic            clk,
  input  logic            reset,
  stream_packer_if.master bus
);

  localparam int              PW       = IN_WIDTH - 1;
  localparam int              CNTW     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(RATIO - 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(RATIO);

  logic [CNTW-1:0]           cnt_q, cnt_d;
  logic [RATIO-1:0][PW-1:0]  lane_q, lane_d;
  logic                      out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]      out_data_q, out_data_d;

  logic [PW-1:0]             payload;
  logic                      is_eot;
  logic                      completes;
  logic                      blocked;
  logic                      rd;
  logic                      wr;
  logic                      acc;
  logic [RATIO-1:0][PW-1:0]  flush_lanes;
  logic [RATIO-1:0][PW-1:0]  full_lanes;

  assign payload   = bus.in_dout[PW-1:0];
  assign is_eot    = bus.in_dout[IN_WIDTH-1];
  assign completes = is_eot | (cnt_q == CNT_LAST);
  assign blocked   = out_valid_q & ~bus.out_full_n;

  // Only a token that would need the holding register is refused while it is stuck.
  assign rd  = ~reset & bus.in_empty_n & ~(blocked & completes);
  assign wr  = ~reset & out_valid_q & bus.out_full_n;
  assign acc = bus.in_empty_n & rd;

  assign bus.in_read   = rd;
  assign bus.out_write = wr;
  assign bus.out_din   = out_data_q;

  generate
    for (genvar g = 0; g < RATIO; g++) begin : g_lane
      assign flush_lanes[g] = (g < int'(cnt_q)) ? lane_q[g] : '0;
      if (g == RATIO - 1) begin : g_last
        assign full_lanes[g] = payload;
      end else begin : g_held
        assign full_lanes[g] = lane_q[g];
      end
    end
  endgenerate

  always_comb begin
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (wr) begin
      out_valid_d = 1'b0;
    end

    if (acc) begin
      if (is_eot) begin
        out_data_d  = {1'b1, CW'(cnt_q), flush_lanes};
        out_valid_d = 1'b1;
        cnt_d       = '0;
        lane_d      = '0;
      end else if (cnt_q == CNT_LAST) begin
        out_data_d  = {1'b0, CNT_FULL, full_lanes};
        out_valid_d = 1'b1;
        cnt_d       = '0;
        lane_d      = '0;
      end else begin
        for (int i = 0; i < RATIO; i++) begin
          if (cnt_q == CNTW'(i)) begin
            lane_d[i] = payload;
          end
        end
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      lane_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_packer.sv
//------------------------------------------------------------------------------
// tb_stream_packer : directed self-checking bench, IN_WIDTH=33, RATIO=4
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_stream_packer;

  localparam int IN_WIDTH  = 33;
  localparam int RATIO     = 4;
  localparam int CW        = 3;
  localparam int OUT_WIDTH = 132;

  logic clk;
  logic reset;

  stream_packer_if #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) bus ();

  stream_packer #(
    .IN_WIDTH (IN_WIDTH),
    .RATIO    (RATIO),
    .CW       (CW),
    .OUT_WIDTH(OUT_WIDTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int n_acc    = 0;

  logic                 last_rd;
  logic                 last_wr;
  logic [OUT_WIDTH-1:0] last_din;
  logic [IN_WIDTH-1:0]  tq[$];
  logic [OUT_WIDTH-1:0] outq[$];
  logic [OUT_WIDTH-1:0] expq[$];

  task automatic check(input string tag, input logic [OUT_WIDTH-1:0] obs,
                       input logic [OUT_WIDTH-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [IN_WIDTH-1:0] tok(input logic e, input logic [31:0] p);
    return {e, p};
  endfunction

  function automatic logic [OUT_WIDTH-1:0] mk_out(input logic e, input logic [CW-1:0] c,
      input logic [31:0] l3, input logic [31:0] l2, input logic [31:0] l1, input logic [31:0] l0);
    return {e, c, l3, l2, l1, l0};
  endfunction

  // One clock: drive at negedge, sample mid-cycle, the DUT acts on the next posedge.
  task automatic cycle(input logic en, input logic [IN_WIDTH-1:0] t,
                       input logic full_n, input logic rst_in);
    @(negedge clk);
    reset          = rst_in;
    bus.in_empty_n = en;
    bus.in_dout    = t;
    bus.out_full_n = full_n;
    #1;
    last_rd  = bus.in_read;
    last_wr  = bus.out_write;
    last_din = bus.out_din;
    if (bus.out_write) outq.push_back(bus.out_din);
  endtask

  // FWFT source: the head stays on in_dout until the DUT reads it.
  task automatic feed(input logic full_n, input int max_cycles);
    int c;
    c = 0;
    while (tq.size() > 0 && c < max_cycles) begin
      cycle(1'b1, tq[0], full_n, 1'b0);
      if (last_rd) begin
        void'(tq.pop_front());
        n_acc++;
      end
      c++;
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic compare_outputs(input string tag);
    check({tag, "_count"}, OUT_WIDTH'(outq.size()), OUT_WIDTH'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      if (i < outq.size()) check($sformatf("%s_out%0d", tag, i), outq[i], expq[i]);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.in_empty_n = 1'b0;
    bus.in_dout    = '0;
    bus.out_full_n = 1'b1;

    // Reset with a token waiting
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, tok(1'b0, 32'h1), 1'b1, 1'b1);
      check("rst_in_read",   OUT_WIDTH'(last_rd), '0);
      check("rst_out_write", OUT_WIDTH'(last_wr), '0);
      check("rst_out_din",   last_din, '0);
    end

    // Full pack with exact latency
    outq.delete();
    cycle(1'b1, tok(1'b0, 32'h1), 1'b1, 1'b0);
    check("first_read", OUT_WIDTH'(last_rd), OUT_WIDTH'(1));
    cycle(1'b1, tok(1'b0, 32'h2), 1'b1, 1'b0);
    cycle(1'b1, tok(1'b0, 32'h3), 1'b1, 1'b0);
    cycle(1'b1, tok(1'b0, 32'h4), 1'b1, 1'b0);
    check("pack_rd4", OUT_WIDTH'(last_rd), OUT_WIDTH'(1));
    check("pack_no_early_wr", OUT_WIDTH'(last_wr), '0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("pack_wr", OUT_WIDTH'(last_wr), OUT_WIDTH'(1));
    check("pack_din", last_din, mk_out(1'b0, 3'd4, 32'h4, 32'h3, 32'h2, 32'h1));
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("pack_single_wr", OUT_WIDTH'(last_wr), '0);

    // Partial flush, restart at lane0, lone EOT
    outq.delete(); expq.delete(); tq.delete();
    tq = '{tok(1'b0, 32'hA), tok(1'b0, 32'hB), tok(1'b1, 32'h5),
           tok(1'b0, 32'h7), tok(1'b1, 32'h0), tok(1'b1, 32'h9)};
    expq = '{mk_out(1'b1, 3'd2, 32'h0, 32'h0, 32'hB, 32'hA),
             mk_out(1'b1, 3'd1, 32'h0, 32'h0, 32'h0, 32'h7),
             mk_out(1'b1, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0)};
    feed(1'b1, 20);
    check("flush_stall", OUT_WIDTH'(tq.size()), '0);
    drain(3);
    compare_outputs("flush");

    // Backpressure: 1..C with the output blocked, then released
    outq.delete(); expq.delete(); tq.delete();
    for (int i = 1; i <= 12; i++) tq.push_back(tok(1'b0, 32'(i)));
    n_acc = 0;
    feed(1'b0, 10);
    check("bp_accepted", OUT_WIDTH'(n_acc), OUT_WIDTH'(7));
    check("bp_rd_drop", OUT_WIDTH'(last_rd), '0);
    check("bp_head_kept", OUT_WIDTH'(tq[0]), OUT_WIDTH'(tok(1'b0, 32'h8)));
    check("bp_no_write", OUT_WIDTH'(outq.size()), '0);
    feed(1'b1, 20);
    check("bp_stall", OUT_WIDTH'(tq.size()), '0);
    drain(3);
    expq = '{mk_out(1'b0, 3'd4, 32'h4, 32'h3, 32'h2, 32'h1),
             mk_out(1'b0, 3'd4, 32'h8, 32'h7, 32'h6, 32'h5),
             mk_out(1'b0, 3'd4, 32'hC, 32'hB, 32'hA, 32'h9)};
    compare_outputs("bp");

    // Reset mid-pack discards partial lanes
    outq.delete(); expq.delete(); tq.delete();
    tq = '{tok(1'b0, 32'h21), tok(1'b0, 32'h22), tok(1'b0, 32'h23)};
    feed(1'b1, 10);
    cycle(1'b1, tok(1'b0, 32'h11), 1'b1, 1'b1);
    check("midrst_in_read", OUT_WIDTH'(last_rd), '0);
    tq = '{tok(1'b0, 32'h11), tok(1'b0, 32'h12), tok(1'b0, 32'h13), tok(1'b0, 32'h14)};
    feed(1'b1, 10);
    check("midrst_stall", OUT_WIDTH'(tq.size()), '0);
    drain(3);
    expq = '{mk_out(1'b0, 3'd4, 32'h14, 32'h13, 32'h12, 32'h11)};
    compare_outputs("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_packer.md
# stream_packer

Width up-converter that sits directly downstream of a relay station. It drains the relay station's FWFT read side and packs RATIO narrow tokens into one wide token. Each wide token is pushed into the write side of the next relay station or FIFO. End-of-transfer (EOT) tagged tokens flush any partial pack, so a stream of any length can be carried across a wider link.

## Interface
Parameters:
- IN_WIDTH, 33, input token width; bit IN_WIDTH-1 is the EOT flag, bits IN_WIDTH-2:0 are the payload (PW = IN_WIDTH-1).
- RATIO, 4, number of payload lanes per output token; must be ≥ 2 (power of two not required).
- CW, $clog2(RATIO+1), derived width of the lane-count field.
- OUT_WIDTH, 1+CW+RATIO*PW, derived output token width.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- in_empty_n  input  1  upstream FWFT has a valid token on in_dout.
- in_read  output  1  pop the upstream token this cycle.
- in_dout  input  IN_WIDTH  upstream head token.
- out_full_n  input  1  downstream can accept a write this cycle; may be an almost-full indication.
- out_write  output  1  push out_din this cycle.
- out_din  output  OUT_WIDTH  {eot, count[CW-1:0], lane[RATIO-1] … lane[0]}; lane0 occupies the LSBs.

## Operation
State:
- cnt (0..RATIO-1): number of lanes already filled.
- lane[RATIO-1:0]: lane registers.
- out_valid: the output holding register is occupied.
- out_data: the output holding register contents.

Definitions:
- acc = in_empty_n & in_read
- is_eot = in_dout[IN_WIDTH-1]
- completes = is_eot | (cnt == RATIO-1)
- blocked = out_valid & ~out_full_n

Read rule:
- in_read = in_empty_n & ~(blocked & completes).
- Non-completing tokens keep draining while the output is blocked.
- in_read is combinational from in_empty_n, in_dout, state and out_full_n.

Write rule:
- out_write = out_valid & out_full_n.
- out_din = out_data.
- out_data is stable while out_valid & ~out_full_n.

On acc of a non-EOT token with cnt < RATIO-1:
- lane[cnt] <= payload.
- cnt <= cnt+1.

On acc of a non-EOT token with cnt == RATIO-1:
- out_data <= {0, RATIO, payload, lane[RATIO-2..0]}.
- out_valid <= 1.
- cnt <= 0.

On acc of an EOT token:
- out_data <= {1, cnt, lanes ≥ cnt zeroed, lanes < cnt as held}.
- out_valid <= 1.
- cnt <= 0.
- The EOT token's payload is discarded.
- If cnt == 0, the output is {1, 0, all-zero payload}.

Holding register:
- If out_write and no completing acc in the same cycle: out_valid <= 0.
- A completing acc in the same cycle as out_write reloads the register (out_valid stays 1).
- This gives zero bubbles.

Lane registers:
- Cleared to 0 when a token is emitted.

Reset:
- cnt=0, lane=0, out_valid=0, out_data=0.
- in_read and out_write are 0 in the reset cycle regardless of inputs.
- Reset mid-pack discards the partial lanes and any pending output token.

Count arithmetic:
- The count field is CW bits.
- RATIO fits exactly (e.g. RATIO=4 → CW=3, full count=3'd4).

## Timing
- Latency: the completing input is accepted in cycle t; out_write may assert in cycle t+1 (if out_full_n=1 in t+1).
- Throughput: 1 input token/cycle sustained when out_full_n stays 1; 1 output token per RATIO inputs.
- Backpressure stall: with out_full_n=0 and out_valid=1, at most RATIO-1 further tokens are absorbed before in_read drops.
- out_write honours out_full_n in the same cycle only; no speculative writes. This keeps the downstream grace period intact.
- out_din is registered (no combinational path from in_dout to out_din).
- Simultaneous out_write and completing acc: the old token is written, the new one is loaded, and out_valid stays 1.

## Test plan
All scenarios use IN_WIDTH=33, RATIO=4 (OUT_WIDTH=132).
- Reset: assert reset 2 cycles with in_empty_n=1 → in_read=0, out_write=0, out_din=0; first read one cycle after reset deasserts.
- Full pack: tokens 0x1,0x2,0x3,0x4 back-to-back, out_full_n=1 → one out_write the cycle after the 4th read, eot=0, count=4, lanes3..0={4,3,2,1}.
- Partial flush: 0xA, 0xB, then an EOT token (payload 0x5) → single output eot=1, count=2, lanes={0,0,0xB,0xA}; the next pack starts at lane0.
- Lone EOT: EOT token with cnt=0 → output eot=1, count=0, payload all zero.
- Backpressure: out_full_n=0, stream 0x1..0xC → first pack is held, in_read drops on the 8th token, 8th token is not lost; on releasing out_full_n, outputs in order {4,3,2,1}, {8,7,6,5}, {C,B,A,9} with no duplicates.
- Reset mid-pack: 3 tokens, reset 1 cycle, then 0x11..0x14 → single output {0x14,0x13,0x12,0x11}, count=4; no stale lanes emitted.
